// File: rtl/bram_accumulator.sv
// Coherent averager: sums N periods of a signed sample stream into a dual-port BRAM.
// The first period writes raw samples; later periods read-modify-write with a fixed 2-cycle latency.
module bram_accumulator #(
    parameter int BRAM_WIDTH = 13,
    parameter int DATA_WIDTH = 14,
    parameter int SUM_WIDTH  = 32,
    parameter int NAVG_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         restart,
    input  logic [NAVG_WIDTH-1:0]        n_avg,
    input  logic                         wen_in,
    input  logic [BRAM_WIDTH-1:0]        addr_in,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic [BRAM_WIDTH-1:0]        bram_raddr,
    input  logic [SUM_WIDTH-1:0]         bram_rdata,
    output logic [BRAM_WIDTH-1:0]        bram_waddr,
    output logic [SUM_WIDTH-1:0]         bram_wdata,
    output logic                         bram_we,
    output logic [NAVG_WIDTH-1:0]        n_cycles,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACCUM, S_DONE} state_t;

    state_t                         r_state;
    logic                           r_wen_d;
    logic                           r_first;
    logic [NAVG_WIDTH-1:0]          r_n_lat;
    logic [NAVG_WIDTH-1:0]          r_n_cycles;
    logic                           r_busy;
    logic                           r_done;

    logic [2:1]                     r_vld_pipe;
    logic [BRAM_WIDTH-1:0]          r_p1_addr;
    logic signed [DATA_WIDTH-1:0]   r_p1_din;
    logic                           r_p1_first;
    logic [BRAM_WIDTH-1:0]          r_p2_addr;
    logic [SUM_WIDTH-1:0]           r_p2_data;

    logic                           w_rise;
    logic                           w_fall;
    logic                           w_accept;
    logic                           w_last;
    logic [NAVG_WIDTH-1:0]          w_n_eff;
    logic [SUM_WIDTH-1:0]           w_p1_ext;

    assign w_rise   = wen_in & ~r_wen_d;
    assign w_fall   = ~wen_in & r_wen_d;
    // A run already high when we arm is ignored until its next rising edge.
    assign w_accept = wen_in & ((r_state == S_ACCUM) | ((r_state == S_ARMED) & w_rise));
    assign w_last   = (r_n_cycles + NAVG_WIDTH'(1)) == r_n_lat;
    assign w_n_eff  = (n_avg == '0) ? NAVG_WIDTH'(1) : n_avg;
    assign w_p1_ext = SUM_WIDTH'(r_p1_din);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_wen_d    <= 1'b0;
            r_first    <= 1'b1;
            r_n_lat    <= NAVG_WIDTH'(1);
            r_n_cycles <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wen_d <= wen_in;
            if (restart) begin
                r_state    <= S_ARMED;
                r_n_cycles <= '0;
                r_first    <= 1'b1;
                r_n_lat    <= w_n_eff;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
            end else begin
                case (r_state)
                    S_ARMED: if (w_rise) r_state <= S_ACCUM;
                    S_ACCUM: begin
                        if (w_fall) begin
                            r_n_cycles <= r_n_cycles + NAVG_WIDTH'(1);
                            r_first    <= 1'b0;
                            if (w_last) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // In-flight entries drain regardless of restart/DONE; only reset cancels them.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_vld_pipe <= '0;
            r_p1_addr  <= '0;
            r_p1_din   <= '0;
            r_p1_first <= 1'b0;
            r_p2_addr  <= '0;
            r_p2_data  <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[1], w_accept};
            r_p1_addr  <= addr_in;
            r_p1_din   <= din;
            r_p1_first <= r_first;
            r_p2_addr  <= r_p1_addr;
            r_p2_data  <= r_p1_first ? w_p1_ext : (bram_rdata + w_p1_ext);
        end
    end

    assign bram_raddr = addr_in;
    assign bram_we    = r_vld_pipe[2];
    assign bram_waddr = r_p2_addr;
    assign bram_wdata = r_p2_data;
    assign n_cycles   = r_n_cycles;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_bram_accumulator.sv
// Randomized bench: two accumulators (32- and 16-bit sums) share one stimulus and are
// checked write-by-write against per-address running sums kept by the bench.
module tb_bram_accumulator;
  localparam int BW = 13;
  localparam int DW = 14;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          restart = 1'b0;
  logic [NW-1:0] n_avg = '0;
  logic          wen_in = 1'b0;
  logic [BW-1:0] addr_in = '0;
  logic [DW-1:0] din = '0;

  logic [BW-1:0] raddr32, waddr32, raddr16, waddr16;
  logic [31:0]   rdata32 = '0, wdata32;
  logic [15:0]   rdata16 = '0, wdata16;
  logic          we32, we16, busy32, busy16, done32, done16;
  logic [NW-1:0] ncyc32, ncyc16;

  bram_accumulator #(.BRAM_WIDTH(BW), .DATA_WIDTH(DW), .SUM_WIDTH(32), .NAVG_WIDTH(NW)) dut (
    .clk(clk), .aresetn(aresetn), .restart(restart), .n_avg(n_avg), .wen_in(wen_in),
    .addr_in(addr_in), .din(din), .bram_raddr(raddr32), .bram_rdata(rdata32),
    .bram_waddr(waddr32), .bram_wdata(wdata32), .bram_we(we32),
    .n_cycles(ncyc32), .busy(busy32), .done(done32));

  bram_accumulator #(.BRAM_WIDTH(BW), .DATA_WIDTH(DW), .SUM_WIDTH(16), .NAVG_WIDTH(NW)) dut16 (
    .clk(clk), .aresetn(aresetn), .restart(restart), .n_avg(n_avg), .wen_in(wen_in),
    .addr_in(addr_in), .din(din), .bram_raddr(raddr16), .bram_rdata(rdata16),
    .bram_waddr(waddr16), .bram_wdata(wdata16), .bram_we(we16),
    .n_cycles(ncyc16), .busy(busy16), .done(done16));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  bit [31:0] mem32 [0:(1<<BW)-1];
  bit [15:0] mem16 [0:(1<<BW)-1];
  always @(posedge clk) begin
    rdata32 <= mem32[raddr32];
    rdata16 <= mem16[raddr16];
    if (we32) mem32[waddr32] <= wdata32;
    if (we16) mem16[waddr16] <= wdata16;
  end

  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference: true (unbounded) per-address sum; each width keeps its low bits
  typedef struct {int cyc; int addr; longint sum;} wr_t;
  wr_t    exp_q[$];
  longint exp_mem [0:(1<<BW)-1];

  always @(negedge clk) begin : mon
    wr_t         e;
    logic [63:0] s;
    if (aresetn && (we32 || we16)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we32", 64'(we32), 64'(0));
        chk("unexpected_we16", 64'(we16), 64'(0));
      end else begin
        e = exp_q.pop_front();
        s = e.sum;
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        chk("we_pair", 64'({we32, we16}), 64'(2'b11));
        chk("waddr32", 64'(waddr32), 64'(e.addr));
        chk("waddr16", 64'(waddr16), 64'(e.addr));
        chk("wdata32", 64'(wdata32), 64'(s[31:0]));
        chk("wdata16", 64'(wdata16), 64'(s[15:0]));
      end
    end
  end

  task automatic chk_status(input string tag, input int nc, input bit bz, input bit dn);
    chk({tag, "_ncyc"}, 64'(ncyc32), 64'(nc));
    chk({tag, "_busy"}, 64'(busy32), 64'(bz));
    chk({tag, "_done"}, 64'(done32), 64'(dn));
    chk({tag, "_ncyc16"}, 64'(ncyc16), 64'(nc));
  endtask

  // mode 0: fixed value, 1: random, 2: addr-4
  task automatic drive_period(input int len, input int gap, input int mode, input int fixed,
                              input bit acc, input bit first_p, input int rst_at, input int rst_navg);
    for (int i = 0; i < len; i++) begin
      int d;
      @(posedge clk); #1;
      d = (mode == 1) ? int'($urandom_range(0, 16383)) - 8192 : (mode == 2) ? i - 4 : fixed;
      wen_in  = 1'b1;
      addr_in = BW'(i);
      din     = DW'(d);
      restart = (i == rst_at);
      if (i == rst_at) n_avg = NW'(rst_navg);
      if (acc && (rst_at < 0 || i <= rst_at)) begin
        if (first_p) exp_mem[i] = d;
        else         exp_mem[i] = exp_mem[i] + d;
        exp_q.push_back('{cyc + 2, i, exp_mem[i]});
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      wen_in  = 1'b0;
      restart = 1'b0;
    end
  endtask

  task automatic check_mem(input int len);
    logic [63:0] s;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < len; a++) begin
      s = exp_mem[a];
      chk("mem32", 64'(mem32[a]), 64'(s[31:0]));
      chk("mem16", 64'(mem16[a]), 64'(s[15:0]));
    end
  endtask

  task automatic do_restart(input int navg);
    @(posedge clk); #1;
    restart = 1'b1;
    n_avg   = NW'(navg);
    @(posedge clk); #1;
    restart = 1'b0;
    chk_status("restart", 0, 1'b1, 1'b0);
  endtask

  task automatic run(input int navg, input int len, input int gap, input int mode,
                     input int f0, input int f1);
    int nlat;
    nlat = (navg == 0) ? 1 : navg;
    do_restart(navg);
    for (int p = 0; p < nlat; p++) begin
      drive_period(len, gap, mode, (p == 0) ? f0 : f1, 1'b1, p == 0, -1, 0);
      chk_status("period", p + 1, p + 1 != nlat, p + 1 == nlat);
    end
    // one more period while DONE: must produce no writes
    drive_period(len, gap, mode, f1, 1'b0, 1'b0, -1, 0);
    chk_status("held", nlat, 1'b0, 1'b1);
    check_mem(len);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk_status("reset", 0, 1'b0, 1'b0);
    chk("reset_we", 64'({we32, we16}), 64'(0));
    aresetn = 1'b1;
    drive_period(8, 2, 1, 0, 1'b0, 1'b0, -1, 0);
    chk_status("idle", 0, 1'b0, 1'b0);

    run(1, 8, 2, 2, 0, 0);
    chk("ramp_neg", 64'(mem32[0]), 64'(32'hFFFF_FFFC));

    run(3, 8, 2, 0, 5, 5);
    chk("sum15", 64'(mem32[7]), 64'(15));

    run(2, 8, 3, 0, -8192, 8191);
    chk("sext32", 64'(mem32[0]), 64'(32'hFFFF_FFFF));
    chk("sext16", 64'(mem16[5]), 64'(16'hFFFF));

    run(5, 4, 2, 0, 8191, 8191);
    chk("wrap16", 64'(mem16[0]), 64'(16'h9FFB));
    chk("nowrap32", 64'(mem32[3]), 64'(40955));

    run(0, 6, 2, 1, 0, 0);
    run(4, 1, 2, 1, 0, 0);

    // restart mid-period at addr 3: samples 4..7 of that period are dropped
    do_restart(2);
    drive_period(8, 2, 0, 5, 1'b1, 1'b1, -1, 0);
    drive_period(8, 2, 0, 5, 1'b1, 1'b0, 3, 1);
    chk_status("midrst", 0, 1'b1, 1'b0);
    check_mem(8);
    chk("midrst_a3", 64'(mem32[3]), 64'(10));
    chk("midrst_a4", 64'(mem32[4]), 64'(5));
    drive_period(8, 2, 0, 1, 1'b1, 1'b1, -1, 0);
    chk_status("midrst_next", 1, 1'b0, 1'b1);
    check_mem(8);

    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(0, 4)), int'($urandom_range(1, 12)), int'($urandom_range(2, 4)), 1, 0, 0);

    // async reset while a write is on the port
    do_restart(2);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      wen_in  = 1'b1;
      addr_in = BW'(i);
      din     = DW'(7);
      exp_mem[i] = 7;
      exp_q.push_back('{cyc + 2, i, exp_mem[i]});
      #1;
      if (we32) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_we_seen", 64'(seen), 64'(1));
    aresetn = 1'b0;
    #1;
    chk("abort_we32", 64'(we32), 64'(0));
    chk("abort_we16", 64'(we16), 64'(0));
    chk_status("abort", 0, 1'b0, 1'b0);
    exp_q.delete();
    wen_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    run(1, 4, 2, 1, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
